onchip_memory_arbiter: RTL and testbench



---
 rtl/onchip_memory_arbiter.sv | 97 +++++++++
 tb/tb_onchip_memory_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_memory_arbiter.sv
// Two-master arbiter in front of the single-port 8192x32 on-chip memory; the read response returns one cycle after acceptance.
// Grant is combinational and there is no added latency. The losing master sees waitrequest. Define ONCHIP_ARB_FIXED_PRIO_EN to make m0 always win.
module onchip_memory_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    logic req0;
    logic req1;
    logic gnt_vld;
    logic gnt_id;
    logic rd_accept;
    logic last;
    logic rsp_valid;
    logic rsp_id;

    always_comb begin
        req0    = m0_read | m0_write;
        req1    = m1_read | m1_write;
        gnt_vld = req0 | req1;
        gnt_id  = 1'b0;
        if (req0 && req1) begin
`ifdef ONCHIP_ARB_FIXED_PRIO_EN
            gnt_id = 1'b0;
`else
            gnt_id = ~last;
`endif
        end else if (req1) begin
            gnt_id = 1'b1;
        end
    end

    // A master that asserts both read and write is treated as a write.
    always_comb begin
        mem_chipselect = gnt_vld;
        mem_address    = gnt_id ? m1_address    : m0_address;
        mem_byteenable = gnt_id ? m1_byteenable : m0_byteenable;
        mem_writedata  = gnt_id ? m1_writedata  : m0_writedata;
        mem_write      = gnt_vld & (gnt_id ? m1_write : m0_write);
        mem_clken      = 1'b1;
        rd_accept      = gnt_vld & ~mem_write;
        m0_waitrequest = req0 & gnt_id;
        m1_waitrequest = req1 & ~gnt_id;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last      <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
        end else begin
            rsp_valid <= rd_accept;
            if (gnt_vld) begin
                last <= gnt_id;
            end
            if (rd_accept) begin
                rsp_id <= gnt_id;
            end
        end
    end

    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = rsp_valid & ~rsp_id;
    assign m1_readdatavalid = rsp_valid & rsp_id;

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Randomized bench for onchip_memory_arbiter. It uses a behavioural memory plus a grant/data reference model.
// The model pushes the expected read responses into per-master queues, and a negedge monitor pops and compares them.
module tb_onchip_memory_arbiter;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] m0_address, m1_address, mem_address;
    logic [BE_W-1:0]   m0_byteenable, m1_byteenable, mem_byteenable;
    logic              m0_read, m1_read, m0_write, m1_write;
    logic [DATA_W-1:0] m0_writedata, m1_writedata, mem_writedata;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    onchip_memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t              q0[$];
    exp_t              q1[$];
    logic [DATA_W-1:0] tb_mem  [0:8191];
    logic [DATA_W-1:0] ref_mem [0:8191];
    int                cyc = 0;
    int                n_pass = 0;
    int                n_total = 0;
    bit                hold0 = 1'b0;
    bit                hold1 = 1'b0;
    int                ref_last = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Behavioural single-port memory; the read data appears the cycle after the command.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_chipselect === 1'b1) begin
            if (mem_write) begin
                for (int b = 0; b < BE_W; b++)
                    if (mem_byteenable[b]) tb_mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= tb_mem[mem_address];
            end
        end
    end

    // Reference model: it judges the command presented in this cycle from the arbitration rules.
    always @(posedge clk) begin : model
        bit                r0, r1, w0, w1, wr;
        int                g;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [BE_W-1:0]   be;
        exp_t              e;
        #3;
        if (reset) begin
            q0.delete();
            q1.delete();
            ref_last = 1;
            hold0 = 1'b0;
            hold1 = 1'b0;
        end else begin
            r0 = m0_read | m0_write;
            r1 = m1_read | m1_write;
            w0 = m0_write;
            w1 = m1_write;
            g = -1;
            if (r0 && !r1) g = 0;
            else if (r1 && !r0) g = 1;
            else if (r0 && r1) begin
`ifdef ONCHIP_ARB_FIXED_PRIO_EN
                g = 0;
`else
                g = 1 - ref_last;
`endif
            end
            chk("m0_waitrequest", m0_waitrequest, {31'd0, r0 && g != 0});
            chk("m1_waitrequest", m1_waitrequest, {31'd0, r1 && g != 1});
            chk("mem_chipselect", mem_chipselect, {31'd0, g >= 0});
            chk("mem_clken", mem_clken, 32'd1);
            if (g >= 0) begin
                a  = (g == 0) ? m0_address    : m1_address;
                d  = (g == 0) ? m0_writedata  : m1_writedata;
                be = (g == 0) ? m0_byteenable : m1_byteenable;
                wr = (g == 0) ? w0 : w1;
                chk("mem_address", {19'd0, mem_address}, {19'd0, a});
                chk("mem_write", {31'd0, mem_write}, {31'd0, wr});
                if (wr) begin
                    chk("mem_byteenable", {28'd0, mem_byteenable}, {28'd0, be});
                    chk("mem_writedata", mem_writedata, d);
                    for (int b = 0; b < BE_W; b++)
                        if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
                end else begin
                    e.due  = cyc + 1;
                    e.data = ref_mem[a];
                    if (g == 0) q0.push_back(e);
                    else q1.push_back(e);
                end
                ref_last = g;
            end else begin
                chk("mem_write_idle", {31'd0, mem_write}, 32'd0);
            end
            hold0 = r0 && m0_waitrequest;
            hold1 = r1 && m1_waitrequest;
        end
    end

    // Monitor: each readdatavalid must match the head of its owner's queue in exactly the due cycle.
    always @(negedge clk) begin
        if (reset) begin
            chk("m0_rdv_in_reset", {31'd0, m0_readdatavalid}, 32'd0);
            chk("m1_rdv_in_reset", {31'd0, m1_readdatavalid}, 32'd0);
        end else begin
            if (q0.size() > 0 && q0[0].due == cyc) begin
                chk("m0_readdatavalid", {31'd0, m0_readdatavalid}, 32'd1);
                chk("m0_readdata", m0_readdata, q0[0].data);
                void'(q0.pop_front());
            end else begin
                chk("m0_spurious_rdv", {31'd0, m0_readdatavalid}, 32'd0);
            end
            if (q1.size() > 0 && q1[0].due == cyc) begin
                chk("m1_readdatavalid", {31'd0, m1_readdatavalid}, 32'd1);
                chk("m1_readdata", m1_readdata, q1[0].data);
                void'(q1.pop_front());
            end else begin
                chk("m1_spurious_rdv", {31'd0, m1_readdatavalid}, 32'd0);
            end
        end
    end

    task automatic drive(input int m, input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
        if (m == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
        end
    endtask

    task automatic idle(input int m);
        drive(m, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cmd(input int m);
        int k;
        logic [ADDR_W-1:0] a;
        k = $urandom_range(0, 9);
        a = ADDR_W'($urandom_range(0, 31));
        if (k < 3) idle(m);
        else drive(m, k >= 3 && k <= 5 || k == 9, k >= 6, a, $urandom, BE_W'($urandom_range(0, 15)));
    endtask

    initial begin
        reset = 1'b1;
        idle(0);
        idle(1);
        for (int i = 0; i < 8192; i++) begin
            tb_mem[i]  = '0;
            ref_mem[i] = '0;
        end
        tb_mem[16]  = 32'hDEADBEEF;
        ref_mem[16] = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // First contention after reset: m0 must win, and then the grant alternates.
        drive(0, 1'b1, 1'b0, 13'h0010, '0, 4'hF);
        drive(1, 1'b1, 1'b0, 13'h0011, '0, 4'hF);
        repeat (6) step();
        idle(0); idle(1); step();

        drive(0, 1'b1, 1'b0, 13'h0010, '0, 4'hF); step();
        idle(0); step();

        drive(1, 1'b0, 1'b1, 13'h0100, 32'h11223344, 4'b0011); step();
        drive(1, 1'b1, 1'b0, 13'h0100, '0, 4'hF); step();
        idle(1); step();

        drive(0, 1'b1, 1'b0, 13'h0004, '0, 4'hF); step();
        idle(0); drive(1, 1'b0, 1'b1, 13'h0004, 32'hCAFEF00D, 4'hF); step();
        idle(1); drive(0, 1'b1, 1'b0, 13'h0004, '0, 4'hF); step();
        idle(0); step();

`ifdef ONCHIP_ARB_FIXED_PRIO_EN
        drive(0, 1'b1, 1'b0, 13'h0010, '0, 4'hF);
        drive(1, 1'b1, 1'b0, 13'h0100, '0, 4'hF);
        repeat (4) step();
        idle(0); step();
        idle(1); step();
`endif

        // Reset lands while a read response is in flight.
        drive(0, 1'b1, 1'b0, 13'h0010, '0, 4'hF); step();
        idle(0); reset = 1'b1;
        repeat (2) step();
        reset = 1'b0; step();
        drive(0, 1'b1, 1'b0, 13'h0010, '0, 4'hF);
        drive(1, 1'b1, 1'b0, 13'h0004, '0, 4'hF);
        repeat (2) step();
        idle(0); idle(1); step();

        for (int i = 0; i < 1500; i++) begin
            if (!hold0) rand_cmd(0);
            if (!hold1) rand_cmd(1);
            step();
        end
        idle(0); idle(1);
        repeat (3) step();
        chk("m0_queue_drained", q0.size(), 32'd0);
        chk("m1_queue_drained", q1.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
